data_mem_ctrl: RTL and testbench
================================

Name: data_mem_ctrl

Overview:
Parametrised data-memory controller for the memory execution unit. Serves LB/LBU/LH/LHU/LW/SB/SH/SW requests against an internal byte-addressed little-endian RAM. Uses a valid/ready request handshake and a valid/ready response handshake. Memory size and wait states are configurable; misaligned and out-of-range accesses return an error response.

Parameters:
MEM_BYTES, 131072, RAM size in bytes; the valid address range is 0..MEM_BYTES-1.
WAIT_STATES, 1, extra cycles between request accept and access commit (0..15).
ADDR_W, 32, request address width.

Ports:
clk  in  1  clock; all state updates on the rising edge.
reset_n  in  1  asynchronous active-low reset.
req_valid  in  1  request present.
req_ready  out  1  controller can accept a request.
req_op  in  3  mem_op_t operation.
req_addr  in  ADDR_W  byte address.
req_wdata  in  32  store data; the low byte/half/word is used.
rsp_valid  out  1  response present.
rsp_ready  in  1  consumer accepts the response.
rsp_rdata  out  32  load result, extended to 32 bits; 0 for stores and errors.
rsp_err  out  1  misaligned or out-of-range access.

Behaviour:
- Reset (reset_n low, asynchronous):
  - state=IDLE; rsp_valid=0, rsp_rdata=0, rsp_err=0, wait counter=0.
  - req_ready=1, since it is decoded from IDLE.
  - RAM contents are not reset.
- States:
  - IDLE: req_ready=1. On req_valid: latch op, addr and wdata. Then:
    - error -> RESP with rsp_err=1;
    - else if WAIT_STATES=0 -> COMMIT action and go to RESP;
    - else -> WAIT with counter=WAIT_STATES-1.
  - WAIT: req_ready=0. Counter decrements each cycle. At counter=0, perform the COMMIT action and go to RESP.
  - RESP: rsp_valid=1, with rsp_rdata and rsp_err stable. On rsp_ready -> IDLE and rsp_valid drops on the next cycle.
- Latency: accept at edge N; rsp_valid is high from edge N+WAIT_STATES+1.
  - Throughput: one request per WAIT_STATES+2 cycles when rsp_ready is held high.
  - No request is accepted while WAIT or RESP.
- COMMIT action:
  - Stores write bytes at addr..addr+size-1, little-endian (byte 0 = wdata[7:0]).
  - Loads read the same bytes and register the result into rsp_rdata.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- Error conditions, checked on the latched request:
  - half at an odd address;
  - word with addr[1:0]!=0;
  - addr+size > MEM_BYTES, computed in ADDR_W+1 bits so there is no wrap-around.
- On error: no RAM write, rsp_rdata=0, rsp_err=1, and the error response is issued one cycle after accept regardless of WAIT_STATES.
- Illegal req_op encodings (none are unused with 3 bits) cannot occur.
- Reset during WAIT: the pending store is dropped and RAM is unchanged. A store already committed stays written.
- Reset during RESP drops the response.
- req_valid deasserting while req_ready=1 is legal. A request is taken only on the edge where req_valid && req_ready.

Decomposition:
- Shared package (my_pkg) holds:
  - typedef enum logic[2:0] mem_op_t {MEM_LB, MEM_LBU, MEM_LH, MEM_LHU, MEM_LW, MEM_SB, MEM_SH, MEM_SW};
  - typedef enum logic[1:0] mem_state_t {IDLE, WAIT, RESP};
  - the constant MEMORY_SIZE=131072, used as the MEM_BYTES default;
  - the existing wires32/wires8 types.
- One combinational sub-module, mem_lane_align, computes:
  - access size;
  - per-byte write enables and write bytes;
  - load extraction with sign/zero extension;
  - misalignment flag.
  The FSM, counter, range check and RAM stay in data_mem_ctrl.

Test Plan:
- Basic store/load (WAIT_STATES=1): SW 0xDEADBEEF @0x100, then:
  - LW @0x100 -> rsp_rdata 0xDEADBEEF, rsp_err 0, rsp_valid 2 cycles after accept;
  - LB @0x103 -> 0xFFFFFFDE; LBU @0x103 -> 0x000000DE;
  - LH @0x102 -> 0xFFFFDEAD; LHU @0x100 -> 0x0000BEEF.
- Partial store: after the above, SB @0x101 wdata 0x00000012 -> LW @0x100 returns 0xDEAD12EF. SH @0x102 wdata 0x5678 -> LW returns 0x567812EF.
- Errors:
  - LW @0x102 -> rsp_err 1, rsp_rdata 0, response 1 cycle after accept.
  - SH @0x101 -> rsp_err 1, and a following LW @0x100 is unchanged.
  - LW @MEM_BYTES-2 -> rsp_err 1.
  - LB @MEM_BYTES-1 -> rsp_err 0.
- Backpressure: hold rsp_ready=0 for 3 cycles on a load -> rsp_valid stays 1, rsp_rdata stable, req_ready 0, and a new req_valid is not accepted until 1 cycle after the rsp handshake.
- Reset mid-operation (WAIT_STATES=3): SW 0x11223344 @0x200 over prior 0xAAAAAAAA, with reset_n pulsed low while in WAIT -> outputs are at their reset values immediately (async), and a later LW @0x200 returns 0xAAAAAAAA.
- Latency sweep: WAIT_STATES=0 gives response at accept+1; WAIT_STATES=2 gives accept+3. Back-to-back loads with rsp_ready=1 are accepted every WAIT_STATES+2 cycles.

Source files
------------

// File: rtl/my_pkg.sv
// Shared types for the memory execution unit: operation and controller state
// encodings plus the default data-memory size.
package my_pkg;

    typedef logic [31:0] wires32;
    typedef logic [7:0]  wires8;

    localparam int MEMORY_SIZE = 131072;

    typedef enum logic [2:0] {
        MEM_LB, MEM_LBU, MEM_LH, MEM_LHU, MEM_LW, MEM_SB, MEM_SH, MEM_SW
    } mem_op_t;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} mem_state_t;

    function automatic logic op_is_store(mem_op_t op);
        return (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for a 32-bit little-endian word: store lane enables and
// replicated write bytes, load extraction with sign/zero extension, alignment.
module mem_lane_align
    import my_pkg::*;
(
    input  mem_op_t     op,
    input  logic [1:0]  addr_lo,
    input  wires32      wdata,
    input  wires32      rword,
    output logic [2:0]  size,
    output logic [3:0]  byte_en,
    output wires32      wbytes,
    output wires32      load_data,
    output logic        misaligned
);

    wires8       rbyte;
    logic [15:0] rhalf;

    always_comb begin
        size       = 3'd4;
        byte_en    = 4'b0000;
        wbytes     = wdata;
        load_data  = rword;
        misaligned = 1'b0;
        rbyte      = rword[{addr_lo, 3'b000} +: 8];
        rhalf      = rword[{addr_lo[1], 4'b0000} +: 16];
        case (op)
            MEM_LB:  begin size = 3'd1; load_data = {{24{rbyte[7]}}, rbyte}; end
            MEM_LBU: begin size = 3'd1; load_data = {24'd0, rbyte}; end
            MEM_LH:  begin
                size = 3'd2; misaligned = addr_lo[0];
                load_data = {{16{rhalf[15]}}, rhalf};
            end
            MEM_LHU: begin
                size = 3'd2; misaligned = addr_lo[0];
                load_data = {16'd0, rhalf};
            end
            MEM_LW:  misaligned = (addr_lo != 2'b00);
            // Narrow stores replicate the data across lanes; byte_en picks the lane.
            MEM_SB:  begin
                size = 3'd1; byte_en = 4'b0001 << addr_lo;
                wbytes = {4{wdata[7:0]}};
            end
            MEM_SH:  begin
                size = 3'd2; misaligned = addr_lo[0];
                byte_en = addr_lo[1] ? 4'b1100 : 4'b0011;
                wbytes = {2{wdata[15:0]}};
            end
            MEM_SW:  begin byte_en = 4'b1111; misaligned = (addr_lo != 2'b00); end
            default: ;
        endcase
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// Data-memory controller: one request at a time through IDLE -> WAIT -> RESP,
// with range/alignment checking and a byte-lane RAM committed after the wait states.
module data_mem_ctrl
    import my_pkg::*;
#(
    parameter int MEM_BYTES   = MEMORY_SIZE,
    parameter int WAIT_STATES = 1,
    parameter int ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
);

    localparam int WORDS = MEM_BYTES / 4;
    localparam int IDX_W = $clog2(WORDS);
    localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
    localparam logic NO_WAIT = (WAIT_STATES == 0);
    localparam logic [ADDR_W:0] MEM_LIMIT = (ADDR_W + 1)'(MEM_BYTES);

    mem_state_t        state_reg, state_next;
    logic [3:0]        cnt_reg;
    mem_op_t           op_reg;
    logic [ADDR_W-1:0] addr_reg;
    wires32            wdata_reg;
    wires32            rdata_reg;
    logic              err_reg;

    mem_op_t           cur_op;
    logic [ADDR_W-1:0] cur_addr;
    wires32            cur_wdata;
    logic              accept, commit, ram_we, out_of_range, access_err;
    logic [ADDR_W:0]   end_addr;
    logic [2:0]        size;
    logic [3:0]        byte_en;
    wires32            wbytes, load_data, rword;
    logic              misaligned;
    logic [IDX_W-1:0]  word_idx;

    // In IDLE the live request is used so a zero-wait access commits on the accept edge.
    always_comb begin
        cur_op    = op_reg;
        cur_addr  = addr_reg;
        cur_wdata = wdata_reg;
        if (state_reg == IDLE) begin
            cur_op    = mem_op_t'(req_op);
            cur_addr  = req_addr;
            cur_wdata = req_wdata;
        end
    end

    mem_lane_align u_lane_align (
        .op         (cur_op),
        .addr_lo    (cur_addr[1:0]),
        .wdata      (cur_wdata),
        .rword      (rword),
        .size       (size),
        .byte_en    (byte_en),
        .wbytes     (wbytes),
        .load_data  (load_data),
        .misaligned (misaligned)
    );

    // One extra bit keeps addresses near the top of the address space from wrapping.
    assign end_addr     = {1'b0, cur_addr} + {{(ADDR_W - 2){1'b0}}, size};
    assign out_of_range = end_addr > MEM_LIMIT;
    assign access_err   = misaligned || out_of_range;
    assign accept       = req_valid && (state_reg == IDLE);
    assign commit       = (accept && !access_err && NO_WAIT) ||
                          ((state_reg == WAIT) && (cnt_reg == 4'd0));
    assign ram_we       = commit && op_is_store(cur_op);
    assign word_idx     = cur_addr[IDX_W+1:2];

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        wires8 lane_mem [WORDS];

        always_ff @(posedge clk) begin
            if (ram_we && byte_en[gi]) begin
                lane_mem[word_idx] <= wbytes[8*gi +: 8];
            end
        end

        assign rword[8*gi +: 8] = lane_mem[word_idx];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (req_valid) begin
                    state_next = (access_err || NO_WAIT) ? RESP : WAIT;
                end
            end
            WAIT:    if (cnt_reg == 4'd0) state_next = RESP;
            RESP:    if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state_reg == IDLE);
        rsp_valid = (state_reg == RESP);
        rsp_rdata = rdata_reg;
        rsp_err   = err_reg;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_reg   <= 4'd0;
            op_reg    <= MEM_LB;
            addr_reg  <= '0;
            wdata_reg <= '0;
            rdata_reg <= '0;
            err_reg   <= 1'b0;
        end else begin
            if (accept) begin
                op_reg    <= cur_op;
                addr_reg  <= cur_addr;
                wdata_reg <= cur_wdata;
                cnt_reg   <= WAIT_LOAD;
                err_reg   <= access_err;
                rdata_reg <= '0;
            end else if ((state_reg == WAIT) && (cnt_reg != 4'd0)) begin
                cnt_reg <= cnt_reg - 4'd1;
            end
            if (commit) begin
                rdata_reg <= op_is_store(cur_op) ? 32'd0 : load_data;
            end
        end
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Scoreboard bench: four controllers with different wait-state counts; the driver
// queues expected responses and a monitor checks them on each response handshake.
module tb_data_mem_ctrl;
    import my_pkg::*;

    localparam int N  = 4;
    localparam int MB = 131072;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n   [N];
    logic        req_valid [N];
    logic        req_ready [N];
    logic [2:0]  req_op    [N];
    logic [31:0] req_addr  [N];
    logic [31:0] req_wdata [N];
    logic        rsp_valid [N];
    logic        rsp_ready [N];
    logic [31:0] rsp_rdata [N];
    logic        rsp_err   [N];

    for (genvar gi = 0; gi < N; gi++) begin : g_dut
        data_mem_ctrl #(
            .MEM_BYTES   (MB),
            .WAIT_STATES ((gi == 0) ? 1 : (gi == 1) ? 3 : (gi == 2) ? 0 : 2),
            .ADDR_W      (32)
        ) u_dut (
            .clk       (clk),
            .reset_n   (reset_n[gi]),
            .req_valid (req_valid[gi]),
            .req_ready (req_ready[gi]),
            .req_op    (req_op[gi]),
            .req_addr  (req_addr[gi]),
            .req_wdata (req_wdata[gi]),
            .rsp_valid (rsp_valid[gi]),
            .rsp_ready (rsp_ready[gi]),
            .rsp_rdata (rsp_rdata[gi]),
            .rsp_err   (rsp_err[gi])
        );
    end

    typedef struct {
        int          dut;
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          acc;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   first_v  [N];
    logic prev_v   [N];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int ws_of(input int i);
        return (i == 0) ? 1 : (i == 1) ? 3 : (i == 2) ? 0 : 2;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_req(input int i, input mem_op_t op, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] er, input logic ee,
                          input logic push, output int acc);
        int n = 0;
        acc = -1;
        while (req_ready[i] !== 1'b1) begin
            tick();
            n++;
            if (n > 50) begin
                chk("req_ready_timeout", 32'd0, 32'd1);
                return;
            end
        end
        req_valid[i] = 1'b1;
        req_op[i]    = op;
        req_addr[i]  = addr;
        req_wdata[i] = wdata;
        acc = cyc;
        if (push) exp_q.push_back('{dut: i, rdata: er, err: ee,
                                    lat: ee ? 1 : ws_of(i) + 1, acc: cyc});
        $display("req  dut%0d cyc=%0d %s addr=0x%08h wdata=0x%08h", i, cyc, op.name(), addr, wdata);
        tick();
        req_valid[i] = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            tick();
            n++;
        end
        if (exp_q.size() != 0) chk("drain_timeout", exp_q.size(), 32'd0);
    endtask

    task automatic tx(input int i, input mem_op_t op, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [31:0] er, input logic ee);
        int a;
        do_req(i, op, addr, wdata, er, ee, 1'b1, a);
        drain();
    endtask

    // Monitor: latency is measured from accept to the first cycle rsp_valid is seen.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (rsp_valid[i] === 1'b1 && prev_v[i] !== 1'b1) first_v[i] = cyc;
                prev_v[i] = rsp_valid[i];
                if (rsp_valid[i] === 1'b1 && rsp_ready[i] === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_rsp", 32'd1, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        $display("rsp  dut%0d cyc=%0d rdata=0x%08h err=%0b lat=%0d",
                                 i, cyc, rsp_rdata[i], rsp_err[i], first_v[i] - e.acc);
                        chk("rsp_dut", i, e.dut);
                        chk("rsp_rdata", rsp_rdata[i], e.rdata);
                        chk("rsp_err", {31'd0, rsp_err[i]}, {31'd0, e.err});
                        chk("rsp_latency", first_v[i] - e.acc, e.lat);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0, a1, a2;
        for (int i = 0; i < N; i++) begin
            reset_n[i] = 1'b0; req_valid[i] = 1'b0; req_op[i] = 3'd0;
            req_addr[i] = '0; req_wdata[i] = '0; rsp_ready[i] = 1'b1;
            prev_v[i] = 1'b0; first_v[i] = 0;
        end
        #1;
        for (int i = 0; i < N; i++) begin
            chk("reset_req_ready", {31'd0, req_ready[i]}, 32'd1);
            chk("reset_rsp_valid", {31'd0, rsp_valid[i]}, 32'd0);
            chk("reset_rsp_rdata", rsp_rdata[i], 32'd0);
            chk("reset_rsp_err", {31'd0, rsp_err[i]}, 32'd0);
        end
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) reset_n[i] = 1'b1;
        tick();

        // Basic store/load and extension, one wait state
        tx(0, MEM_SW,  32'h100, 32'hDEADBEEF, 32'h0,        1'b0);
        tx(0, MEM_LW,  32'h100, 32'h0,        32'hDEADBEEF, 1'b0);
        tx(0, MEM_LB,  32'h103, 32'h0,        32'hFFFFFFDE, 1'b0);
        tx(0, MEM_LBU, 32'h103, 32'h0,        32'h000000DE, 1'b0);
        tx(0, MEM_LH,  32'h102, 32'h0,        32'hFFFFDEAD, 1'b0);
        tx(0, MEM_LHU, 32'h100, 32'h0,        32'h0000BEEF, 1'b0);
        tx(0, MEM_SB,  32'h101, 32'h00000012, 32'h0,        1'b0);
        tx(0, MEM_LW,  32'h100, 32'h0,        32'hDEAD12EF, 1'b0);
        tx(0, MEM_SH,  32'h102, 32'h00005678, 32'h0,        1'b0);
        tx(0, MEM_LW,  32'h100, 32'h0,        32'h567812EF, 1'b0);

        // Errors: misalignment, range, and no write on an erroring store
        tx(0, MEM_LW,  32'h102,   32'h0,        32'h0,        1'b1);
        tx(0, MEM_SH,  32'h101,   32'h0000FFFF, 32'h0,        1'b1);
        tx(0, MEM_LW,  32'h100,   32'h0,        32'h567812EF, 1'b0);
        tx(0, MEM_SW,  32'h20100, 32'h0BADBEEF, 32'h0,        1'b1);
        tx(0, MEM_LW,  32'h100,   32'h0,        32'h567812EF, 1'b0);
        tx(0, MEM_LW,  MB - 2,    32'h0,        32'h0,        1'b1);
        tx(0, MEM_SH,  MB - 2,    32'h00007F01, 32'h0,        1'b0);
        tx(0, MEM_LHU, MB - 2,    32'h0,        32'h00007F01, 1'b0);
        tx(0, MEM_SB,  MB - 1,    32'h00000080, 32'h0,        1'b0);
        tx(0, MEM_LB,  MB - 1,    32'h0,        32'hFFFFFF80, 1'b0);
        tx(0, MEM_LH,  MB - 2,    32'h0,        32'hFFFF8001, 1'b0);
        tx(0, MEM_LW,  MB,        32'h0,        32'h0,        1'b1);
        tx(0, MEM_LW,  32'hFFFFFFFC, 32'h0,     32'h0,        1'b1);

        // Backpressure: response held while rsp_ready is low
        rsp_ready[0] = 1'b0;
        do_req(0, MEM_LW, 32'h100, 32'h0, 32'h567812EF, 1'b0, 1'b1, a0);
        tick();
        for (int k = 0; k < 3; k++) begin
            chk("bp_rsp_valid", {31'd0, rsp_valid[0]}, 32'd1);
            chk("bp_rsp_rdata", rsp_rdata[0], 32'h567812EF);
            chk("bp_req_ready", {31'd0, req_ready[0]}, 32'd0);
            tick();
        end
        rsp_ready[0] = 1'b1;
        chk("bp_ready_before_hs", {31'd0, req_ready[0]}, 32'd0);
        tick();
        chk("bp_ready_after_hs", {31'd0, req_ready[0]}, 32'd1);
        chk("bp_valid_after_hs", {31'd0, rsp_valid[0]}, 32'd0);
        drain();

        // Reset while a store is waiting to commit
        tx(1, MEM_SW, 32'h200, 32'hAAAAAAAA, 32'h0, 1'b0);
        do_req(1, MEM_SW, 32'h200, 32'h11223344, 32'h0, 1'b0, 1'b0, a0);
        tick();
        reset_n[1] = 1'b0;
        #1;
        chk("midrst_req_ready", {31'd0, req_ready[1]}, 32'd1);
        chk("midrst_rsp_valid", {31'd0, rsp_valid[1]}, 32'd0);
        chk("midrst_rsp_rdata", rsp_rdata[1], 32'd0);
        chk("midrst_rsp_err", {31'd0, rsp_err[1]}, 32'd0);
        tick();
        reset_n[1] = 1'b1;
        tick();
        tx(1, MEM_LW, 32'h200, 32'h0, 32'hAAAAAAAA, 1'b0);

        // Latency and throughput with zero and two wait states
        tx(2, MEM_SW, 32'h0, 32'h01020304, 32'h0, 1'b0);
        tx(2, MEM_LW, 32'h0, 32'h0, 32'h01020304, 1'b0);
        do_req(2, MEM_LW,  32'h0, 32'h0, 32'h01020304, 1'b0, 1'b1, a0);
        do_req(2, MEM_LBU, 32'h1, 32'h0, 32'h00000003, 1'b0, 1'b1, a1);
        do_req(2, MEM_LHU, 32'h2, 32'h0, 32'h00000102, 1'b0, 1'b1, a2);
        drain();
        chk("tput_ws0_gap1", a1 - a0, 32'd2);
        chk("tput_ws0_gap2", a2 - a1, 32'd2);

        tx(3, MEM_SW, 32'h40, 32'hCAFEF00D, 32'h0, 1'b0);
        tx(3, MEM_LH, 32'h41, 32'h0, 32'h0, 1'b1);
        do_req(3, MEM_LW,  32'h40, 32'h0, 32'hCAFEF00D, 1'b0, 1'b1, a0);
        do_req(3, MEM_LB,  32'h43, 32'h0, 32'hFFFFFFCA, 1'b0, 1'b1, a1);
        do_req(3, MEM_LHU, 32'h42, 32'h0, 32'h0000CAFE, 1'b0, 1'b1, a2);
        drain();
        chk("tput_ws2_gap1", a1 - a0, 32'd4);
        chk("tput_ws2_gap2", a2 - a1, 32'd4);

        repeat (3) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
